pattern_seq_controller: RTL and testbench

//  Sequences the two-button pattern detector. Takes both debounced button levels, converts presses
//  to symbols (button0 = LOW/0, button1 = HIGH/1), arbitrates simultaneous presses, and buffers them
//  in a small FIFO. Feeds the detector one symbol per valid/ready handshake. Clears the detector after

---
 rtl/pattern_ctrl_pkg.sv | 13 +
 rtl/pattern_seq_controller_sym_fifo.sv | 65 ++++++
 rtl/pattern_seq_controller.sv | 172 +++++++++++++++++
 tb/tb_pattern_seq_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_ctrl_pkg.sv
// Shared types and symbol encodings for the pattern sequencer.
package pattern_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic SYM_LOW  = 1'b0;
    localparam logic SYM_HIGH = 1'b1;

endpackage

// File: rtl/pattern_seq_controller_sym_fifo.sv
// 1-bit symbol FIFO with a two-symbol push port. push1 is only honoured
// together with push0 (it is the second-ordered symbol of a dual press).
// A pop in the same cycle frees a slot for the incoming pushes.
module sym_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push0,
    input  logic                     i_sym0,
    input  logic                     i_push1,
    input  logic                     i_sym1,
    input  logic                     i_pop,
    output logic                     o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free,
    output logic                     o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;

    logic [CW-1:0]    w_free;
    logic [CW-1:0]    w_avail;
    logic             w_pop;
    logic             w_acc0;
    logic             w_acc1;
    logic [AW-1:0]    w_wr1;

    assign w_pop   = i_pop && (r_cnt != '0);
    assign w_free  = CW'(DEPTH) - r_cnt;
    assign w_avail = w_free + CW'(w_pop);
    assign w_acc0  = i_push0 && (w_avail != '0);
    assign w_acc1  = i_push0 && i_push1 && (w_avail >= CW'(2));
    assign w_wr1   = r_wr + AW'(1);

    assign o_drop  = (i_push0 && !w_acc0) || (i_push1 && !w_acc1);
    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_free  = w_free;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_acc0) + AW'(w_acc1);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop);
        end
    end

    // Storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge i_clk) begin
        if (w_acc0) r_mem[r_wr]  <= i_sym0;
        if (w_acc1) r_mem[w_wr1] <= i_sym1;
    end

endmodule

// File: rtl/pattern_seq_controller.sv
// Two-button pattern sequencer: press detection, round-robin arbitration of
// dual presses, symbol buffering, detector handshake, idle clear and match count.
module pattern_seq_controller
    import pattern_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CLEAR_CYCLES   = 2,
    parameter int CNT_W          = 8
) (
    input  logic             sysclock,
    input  logic             rst_n,
    input  logic [1:0]       btn_level,
    output logic             sym_valid,
    output logic             sym_bit,
    input  logic             sym_ready,
    output logic             det_clear,
    input  logic             z,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic             busy
);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam int CCW = $clog2(CLEAR_CYCLES) + 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CCW-1:0] CLR_LAST = CCW'(CLEAR_CYCLES - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [1:0]       r_btn;
    logic [1:0]       r_btn_d;
    logic [1:0]       w_press;
    logic             r_rr;
    logic             w_push0, w_sym0, w_push1, w_sym1;
    logic             w_head, w_empty, w_drop, w_xfer;
    logic [FCW-1:0]   w_free;
    state_t           r_state, w_state_nxt;
    logic             r_fed;
    logic [TW-1:0]    r_tmo;
    logic [CCW-1:0]   r_clr_cnt;
    logic             r_z, r_z_d, r_mpulse, r_ovf;
    logic [CNT_W-1:0] r_mcnt;

    // Reset asserts immediately, deasserts two clean edges later.
    always_ff @(posedge sysclock or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Register buttons and keep the previous sample for rising-edge detect.
    always_ff @(posedge sysclock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_btn   <= '0;
            r_btn_d <= '0;
            r_rr    <= 1'b0;
        end else begin
            r_btn   <= btn_level;
            r_btn_d <= r_btn;
            if (w_press == 2'b11) r_rr <= ~r_rr;
        end
    end
    assign w_press = r_btn & ~r_btn_d;

    // Order presses into up to two symbols; rr picks who goes first on a tie.
    always_comb begin
        w_push0 = 1'b0;
        w_sym0  = SYM_LOW;
        w_push1 = 1'b0;
        w_sym1  = SYM_LOW;
        case (w_press)
            2'b01: begin w_push0 = 1'b1; w_sym0 = SYM_LOW;  end
            2'b10: begin w_push0 = 1'b1; w_sym0 = SYM_HIGH; end
            2'b11: begin
                w_push0 = 1'b1; w_sym0 = r_rr;
                w_push1 = 1'b1; w_sym1 = ~r_rr;
            end
            default: ;
        endcase
    end

    sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (sysclock),
        .i_rst_n (w_rst_n),
        .i_push0 (w_push0),
        .i_sym0  (w_sym0),
        .i_push1 (w_push1),
        .i_sym1  (w_sym1),
        .i_pop   (w_xfer),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_free  (w_free),
        .o_drop  (w_drop)
    );

    assign w_xfer = (r_state == SEND) && sym_ready;

    // State register.
    always_ff @(posedge sysclock or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state; SEND stays put while anything remains after this pop
    // (including a symbol arriving the same cycle) to keep 1 symbol/cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty)                         w_state_nxt = SEND;
                else if (r_fed && (r_tmo == TMO_LAST)) w_state_nxt = CLEAR;
            end
            SEND: begin
                if (w_xfer && (w_free == FCW'(FIFO_DEPTH - 1)) && !w_push0)
                    w_state_nxt = IDLE;
            end
            CLEAR: begin
                if (r_clr_cnt == CLR_LAST) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Inactivity timer, fed flag and clear-pulse length counter.
    always_ff @(posedge sysclock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fed     <= 1'b0;
            r_tmo     <= '0;
            r_clr_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_fed <= 1'b1;
                r_tmo <= '0;
            end else if ((r_state == CLEAR) && (r_clr_cnt == CLR_LAST)) begin
                r_fed <= 1'b0;
                r_tmo <= '0;
            end else if ((r_state == IDLE) && r_fed && (r_tmo != TMO_LAST)) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if ((r_state == CLEAR) && (r_clr_cnt != CLR_LAST)) r_clr_cnt <= r_clr_cnt + CCW'(1);
            else                                                r_clr_cnt <= '0;
        end
    end

    // Match edge detect, saturating counter and sticky overflow.
    always_ff @(posedge sysclock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_z      <= 1'b0;
            r_z_d    <= 1'b0;
            r_mpulse <= 1'b0;
            r_mcnt   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_z      <= z;
            r_z_d    <= r_z;
            r_mpulse <= r_z & ~r_z_d;
            if (r_z && !r_z_d && (r_mcnt != '1)) r_mcnt <= r_mcnt + CNT_W'(1);
            r_ovf    <= r_ovf | w_drop;
        end
    end

    assign sym_valid   = (r_state == SEND);
    assign sym_bit     = sym_valid & w_head;
    assign det_clear   = (r_state == CLEAR);
    assign match_pulse = r_mpulse;
    assign match_count = r_mcnt;
    assign overflow    = r_ovf;
    assign busy        = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_pattern_seq_controller.sv
// Directed + randomized bench for pattern_seq_controller with a transaction-level model.
module tb_pattern_seq_controller;
    localparam int DEPTH = 4;
    localparam int CNTW  = 2;

    logic            sysclock = 1'b0;
    logic            rst_n;
    logic [1:0]      btn_level;
    logic            sym_valid, sym_bit, sym_ready, det_clear, z;
    logic            match_pulse, overflow, busy;
    logic [CNTW-1:0] match_count;

    int vectors = 0;
    int errs    = 0;
    int pulses  = 0;
    int m_rise  = 0;
    logic m_rr  = 1'b0;
    logic m_ovf = 1'b0;
    logic exp_q[$];

    pattern_seq_controller #(
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(16), .CLEAR_CYCLES(2), .CNT_W(CNTW)
    ) dut (
        .sysclock(sysclock), .rst_n(rst_n), .btn_level(btn_level),
        .sym_valid(sym_valid), .sym_bit(sym_bit), .sym_ready(sym_ready),
        .det_clear(det_clear), .z(z), .match_pulse(match_pulse),
        .match_count(match_count), .overflow(overflow), .busy(busy)
    );

    always #5 sysclock = ~sysclock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_cnt(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    // Model: every press becomes symbols in press order; a full buffer drops.
    task automatic push_model(input logic [1:0] p);
        logic s [$];
        if (p == 2'b11) begin
            s.push_back(m_rr); s.push_back(~m_rr); m_rr = ~m_rr;
        end else begin
            s.push_back(p == 2'b10);
        end
        foreach (s[i]) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(s[i]);
            else m_ovf = 1'b1;
        end
    endtask

    // One clock: checks any handshake at the edge and the hold rule.
    task automatic tick();
        logic v, r, b;
        v = sym_valid; r = sym_ready; b = sym_bit;
        @(posedge sysclock); #1;
        if (v && r) begin
            chk("xfer_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("sym_order", b, exp_q.pop_front());
        end
        if (v && !r && rst_n) begin
            chk("valid_hold", sym_valid, 1);
            chk("bit_hold", sym_bit, b);
        end
        if (match_pulse) pulses++;
    endtask

    initial begin
        int clr_seen;
        int holds [5] = '{1, 10, 1, 2, 1};
        logic s, nz;
        rst_n = 1'b0; btn_level = 2'b00; sym_ready = 1'b0; z = 1'b0;
        repeat (3) tick();
        chk("rst_valid", sym_valid, 0);   chk("rst_bit", sym_bit, 0);
        chk("rst_clear", det_clear, 0);   chk("rst_pulse", match_pulse, 0);
        chk("rst_count", match_count, 0); chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // No clear while nothing has been sent.
        clr_seen = 0;
        repeat (40) begin tick(); if (det_clear) clr_seen++; end
        chk("no_clear_unfed", clr_seen, 0);

        // Single press latency.
        sym_ready = 1'b1; btn_level = 2'b10; push_model(2'b10);
        tick(); chk("lat_n0_valid", sym_valid, 0);
        tick(); chk("lat_n1_valid", sym_valid, 0); chk("lat_n1_busy", busy, 1);
        tick(); chk("lat_n2_valid", sym_valid, 1); chk("lat_n2_bit", sym_bit, 1);
        tick(); chk("post_xfer_busy", busy, 0); chk("post_xfer_valid", sym_valid, 0);
        chk("single_drained", exp_q.size(), 0);
        btn_level = 2'b00;

        // Timeout clear: exactly two cycles, 16 after the transfer.
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("det_clear_k%0d", k), det_clear, (k == 16 || k == 17));
        end
        clr_seen = 0;
        repeat (40) begin tick(); if (det_clear) clr_seen++; end
        chk("no_second_clear", clr_seen, 0);

        // Dual presses: rr order and back-to-back transfers.
        btn_level = 2'b11; push_model(2'b11);
        tick(); tick(); tick(); chk("dual_valid", sym_valid, 1); chk("dual_first", sym_bit, 0);
        tick(); chk("b2b_valid", sym_valid, 1); chk("b2b_second", sym_bit, 1);
        tick(); chk("dual_done", sym_valid, 0);
        btn_level = 2'b00; tick(); tick();
        btn_level = 2'b11; push_model(2'b11);
        repeat (6) tick();
        btn_level = 2'b00; repeat (2) tick();
        chk("dual_drained", exp_q.size(), 0);
        chk("dual_ovf", overflow, 0);

        // Backpressure: five presses into a four-deep buffer.
        sym_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s = 1'($urandom_range(0, 1));
            btn_level = s ? 2'b10 : 2'b01; push_model(btn_level);
            tick(); btn_level = 2'b00; tick();
        end
        tick(); tick();
        chk("bp_ovf", overflow, m_ovf);
        chk("bp_valid", sym_valid, 1);
        chk("bp_busy", busy, 1);
        sym_ready = 1'b1;
        repeat (6) tick();
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_busy_end", busy, 0);
        chk("bp_ovf_sticky", overflow, 1);

        // Reset while a symbol is being offered.
        sym_ready = 1'b0; btn_level = 2'b10;
        tick(); tick(); tick();
        chk("mid_valid", sym_valid, 1);
        #2 rst_n = 1'b0; #1;
        chk("mid_rst_valid", sym_valid, 0);   chk("mid_rst_bit", sym_bit, 0);
        chk("mid_rst_clear", det_clear, 0);   chk("mid_rst_pulse", match_pulse, 0);
        chk("mid_rst_count", match_count, 0); chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete(); m_rr = 1'b0; m_ovf = 1'b0; m_rise = 0; pulses = 0;
        btn_level = 2'b00;
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("after_rst_busy", busy, 0);
        chk("after_rst_valid", sym_valid, 0);

        // Match pulses with saturation.
        for (int i = 0; i < 5; i++) begin
            z = 1'b1; m_rise++;
            repeat (holds[i]) tick();
            z = 1'b0;
            repeat (3) tick();
            chk($sformatf("match_count_%0d", i), match_count, sat_cnt(m_rise));
            chk($sformatf("match_pulses_%0d", i), pulses, m_rise);
        end

        // Random presses, ready and z against the model.
        repeat (300) begin
            sym_ready = 1'($urandom_range(0, 1));
            if (btn_level != 2'b00) btn_level = 2'b00;
            else if ($urandom_range(0, 3) == 0 && exp_q.size() <= 2) begin
                btn_level = 2'($urandom_range(1, 3));
                push_model(btn_level);
            end
            nz = 1'($urandom_range(0, 1));
            if (nz && !z) m_rise++;
            z = nz;
            tick();
        end
        z = 1'b0; btn_level = 2'b00; sym_ready = 1'b1;
        repeat (40) tick();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_busy", busy, 0);
        chk("rand_ovf", overflow, m_ovf);
        chk("rand_count", match_count, sat_cnt(m_rise));
        chk("rand_pulses", pulses, m_rise);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
